// File: rtl/snitch_pkg.sv
// Shared definitions for the TCDM bank responder.
// Holds the default bank request/response layouts, the legal bounds for the
// SRAM latency and response-buffer depth, and a small width helper.
package snitch_pkg;

    localparam int unsigned BankAddrWidth = 32;
    localparam int unsigned BankDataWidth = 32;
    localparam int unsigned BankStrbWidth = BankDataWidth / 8;

    // Legal parameter bounds for tcdm_bank_responder.
    localparam int unsigned SramLatencyMin = 1;
    localparam int unsigned SramLatencyMax = 3;
    localparam int unsigned RspDepthMin    = 1;

    typedef struct packed {
        logic [BankAddrWidth-1:0] addr;
        logic                     write;
        logic [BankDataWidth-1:0] wdata;
        logic [BankStrbWidth-1:0] strb;
    } bank_req_t;

    typedef struct packed {
        logic [BankDataWidth-1:0] rdata;
        logic                     write;
    } bank_rsp_t;

    // Index width that never collapses to zero bits (a single requester
    // still needs a 1-bit source field).
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO used as the response buffer.
// Ports:
//   clk_i, rst_i       clock and asynchronous active-high reset
//   full_o, empty_o    status; with FallThrough=1 a push into an empty FIFO
//                      is visible on data_o / empty_o in the same cycle
//   data_i, push_i     write side
//   data_o, pop_i      read side (pop is ignored while empty)
module fifo_v3 #(
    parameter bit          FallThrough = 1'b0,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Depth       = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 full_o,
    output logic                 empty_o,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 push_i,
    output logic [DataWidth-1:0] data_o,
    input  logic                 pop_i
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);

    logic [DataWidth-1:0] mem_reg [Depth];
    logic [PtrWidth-1:0]  wptr_reg, wptr_next;
    logic [PtrWidth-1:0]  rptr_reg, rptr_next;
    logic [CntWidth-1:0]  count_reg, count_next;
    logic                 do_push, do_pop, bypass;

    always_comb begin
        full_o  = (count_reg == DepthCnt);
        empty_o = (count_reg == '0) && !(FallThrough && push_i);
        data_o  = (FallThrough && (count_reg == '0)) ? data_i : mem_reg[rptr_reg];

        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        // An empty fall-through FIFO that is pushed and popped in the same
        // cycle passes the word straight through and stores nothing.
        bypass  = FallThrough && (count_reg == '0) && do_push && do_pop;
        if (bypass) begin
            do_push = 1'b0;
            do_pop  = 1'b0;
        end

        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        if (do_push) begin
            wptr_next = (wptr_reg == LastPtr) ? '0 : wptr_reg + 1'b1;
        end
        if (do_pop) begin
            rptr_next = (rptr_reg == LastPtr) ? '0 : rptr_reg + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
        end
    end

    // Storage carries no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_reg[wptr_reg] <= data_i;
        end
    end

endmodule

// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: turns crossbar requests into SRAM accesses and
// returns in-order responses tagged with the originating requester.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_i, req_src_i             request payload and requester index
//   req_valid_i / req_ready_o    request handshake
//   rsp_o, rsp_sel_o             response payload and requester index
//   rsp_valid_o / rsp_ready_i    response handshake
//   sram_*                       single-port SRAM access (issued in the
//                                accept cycle), sram_rdata_i returns
//                                SramLatency cycles later
module tcdm_bank_responder import snitch_pkg::*; #(
    parameter int unsigned NumInp        = 4,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned SramAddrWidth = 10,
    parameter int unsigned SramLatency   = 1,
    parameter int unsigned RspDepth      = 4,
    parameter type         bank_req_t    = snitch_pkg::bank_req_t,
    parameter type         bank_rsp_t    = snitch_pkg::bank_rsp_t,
    localparam int unsigned SrcWidth     = clog2_min1(NumInp),
    localparam int unsigned StrbWidth    = DataWidth / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  bank_req_t                req_i,
    input  logic [SrcWidth-1:0]      req_src_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    output bank_rsp_t                rsp_o,
    output logic [SrcWidth-1:0]      rsp_sel_o,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic                     sram_req_o,
    output logic                     sram_we_o,
    output logic [SramAddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0]     sram_wdata_o,
    output logic [StrbWidth-1:0]     sram_be_o,
    input  logic [DataWidth-1:0]     sram_rdata_i
);

    localparam int unsigned AddrLsb   = (StrbWidth > 1) ? $clog2(StrbWidth) : 0;
    localparam int unsigned CntWidth  = $clog2(RspDepth + 1);
    localparam logic [CntWidth-1:0] RspDepthCnt = CntWidth'(RspDepth);
    localparam int unsigned FifoWidth = $bits(bank_rsp_t) + SrcWidth;

    typedef struct packed {
        logic                valid;
        logic                write;
        logic [SrcWidth-1:0] src;
    } pipe_t;

    logic [CntWidth-1:0]  outstanding_reg, outstanding_next;
    pipe_t                pipe_reg  [SramLatency];
    pipe_t                pipe_next [SramLatency];
    pipe_t                exit_entry;
    bank_rsp_t            push_rsp;
    logic [FifoWidth-1:0] fifo_rdata;
    logic                 fifo_empty, fifo_full;
    logic                 accept, retire;
    logic                 unused_bits;

    // Ready comes from the registered count only, so a slot freed by a
    // response handshake becomes usable one cycle later.
    assign req_ready_o = (outstanding_reg < RspDepthCnt) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;
    assign retire      = rsp_valid_o && rsp_ready_i;

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (accept) begin
            sram_req_o   = 1'b1;
            sram_we_o    = req_i.write;
            sram_addr_o  = req_i.addr[AddrLsb +: SramAddrWidth];
            sram_wdata_o = req_i.wdata;
            sram_be_o    = req_i.strb;
        end
    end

    // Tag pipeline tracking the SRAM latency; it never stalls because the
    // outstanding limit guarantees room in the response FIFO at exit.
    for (genvar gi = 0; gi < SramLatency; gi++) begin : g_pipe
        if (gi == 0) begin : g_head
            assign pipe_next[gi] = '{valid: accept, write: req_i.write, src: req_src_i};
        end else begin : g_body
            assign pipe_next[gi] = pipe_reg[gi-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SramLatency; i++) begin
                pipe_reg[i] <= '0;
            end
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    assign exit_entry = pipe_reg[SramLatency-1];

    always_comb begin
        push_rsp       = '0;
        push_rsp.write = exit_entry.write;
        push_rsp.rdata = exit_entry.write ? '0 : sram_rdata_i;
    end

    fifo_v3 #(
        .FallThrough (1'b1),
        .DataWidth   (FifoWidth),
        .Depth       (RspDepth)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  ({push_rsp, exit_entry.src}),
        .push_i  (exit_entry.valid),
        .data_o  (fifo_rdata),
        .pop_i   (rsp_ready_i)
    );

    assign rsp_valid_o = !fifo_empty;

    always_comb begin
        rsp_o     = '0;
        rsp_sel_o = '0;
        if (rsp_valid_o) begin
            {rsp_o, rsp_sel_o} = fifo_rdata;
        end
    end

    always_comb begin
        outstanding_next = outstanding_reg;
        if (accept && !retire) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (!accept && retire) begin
            outstanding_next = outstanding_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_reg <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
        end
    end

    // Address bits outside the bank word index and the FIFO full flag are
    // intentionally not consumed.
    assign unused_bits = ^{fifo_full, req_i};

endmodule

// File: tb/tb_tcdm_bank_responder.sv
module tb_tcdm_bank_responder;
    import snitch_pkg::*;

    localparam int unsigned SramLatency = 2;
    localparam int unsigned RspDepth    = 4;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  src;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    bank_req_t   req;
    logic [1:0]  req_src;
    logic        req_valid, req_ready;
    bank_rsp_t   rsp;
    logic [1:0]  rsp_sel;
    logic        rsp_valid, rsp_ready;
    logic        sram_req, sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic [3:0]  sram_be;

    logic [31:0] mem [1024];
    logic [31:0] rd0, rd1;

    item_t items[$];
    int    n_acc, n_ret, offer_limit, cyc, guard;
    int    first_acc, last_acc, first_ret, last_ret;
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    tcdm_bank_responder #(
        .NumInp        (4),
        .DataWidth     (32),
        .SramAddrWidth (10),
        .SramLatency   (SramLatency),
        .RspDepth      (RspDepth)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_src_i    (req_src),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .rsp_o        (rsp),
        .rsp_sel_o    (rsp_sel),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata)
    );

    // SRAM stand-in with a two-cycle read latency and byte enables.
    always @(posedge clk) begin
        if (sram_req && sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
        end
        rd0 <= (sram_req && !sram_we) ? mem[sram_addr] : 32'h0;
        rd1 <= rd0;
    end
    assign sram_rdata = rd1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic item_t make_rd(input int word, input int src);
        item_t it;
        it.addr  = 32'(word) << 2;
        it.write = 1'b0;
        it.wdata = 32'h0;
        it.strb  = 4'h0;
        it.src   = 2'(src);
        return it;
    endfunction

    // Preloaded word w holds 0xA000_0000 | w; writes answer with zero data.
    function automatic logic [31:0] exp_rdata(input item_t it);
        return it.write ? 32'h0 : (32'hA000_0000 | (it.addr >> 2));
    endfunction

    task automatic set_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] src, input logic v);
        req.addr  = a;
        req.write = w;
        req.wdata = d;
        req.strb  = s;
        req_src   = src;
        req_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic reset_book();
        items.delete();
        n_acc = 0;
        n_ret = 0;
        offer_limit = 99;
    endtask

    // One bus cycle: offer the next pending item, log handshakes, compare responses.
    task automatic step();
        if (n_acc < offer_limit && n_acc < items.size()) begin
            set_req(items[n_acc].addr, items[n_acc].write, items[n_acc].wdata,
                    items[n_acc].strb, items[n_acc].src, 1'b1);
        end else begin
            set_req(32'h0, 1'b0, 32'h0, 4'h0, 2'h0, 1'b0);
        end
        #1;
        if (rsp_valid && rsp_ready) begin
            if (n_ret < items.size()) begin
                $display("rsp #%0d cyc=%0d sel=%0d write=%0d rdata=0x%08h", n_ret, cyc, rsp_sel, rsp.write, rsp.rdata);
                check("rsp_sel", 64'(rsp_sel), 64'(items[n_ret].src));
                check("rsp_write", 64'(rsp.write), 64'(items[n_ret].write));
                check("rsp_rdata", 64'(rsp.rdata), 64'(exp_rdata(items[n_ret])));
                if (n_ret == 0) first_ret = cyc;
                last_ret = cyc;
                n_ret++;
            end else begin
                check("rsp_spurious", 64'(rsp_valid), 64'(0));
            end
        end
        if (req_valid && req_ready) begin
            $display("acc #%0d cyc=%0d addr=0x%08h src=%0d", n_acc, cyc, req.addr, req_src);
            if (n_acc == 0) first_acc = cyc;
            last_acc = cyc;
            n_acc++;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
        rst = 1'b1;
        rsp_ready = 1'b0;
        cyc = 0;
        set_req(32'h0, 1'b0, 32'h0, 4'h0, 2'h0, 1'b0);
        reset_book();

        // Reset state, with a request offered to prove nothing gets through.
        tick();
        set_req(32'h40, 1'b1, 32'h1234, 4'hF, 2'd1, 1'b1);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_sram_req", 64'(sram_req), 64'(0));
        check("rst_sram_wdata", 64'(sram_wdata), 64'(0));
        check("rst_rsp_sel", 64'(rsp_sel), 64'(0));
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'(1));
        tick();

        // Write then read word 0x10, byte-strobed write, read back.
        rsp_ready = 1'b1;
        set_req(32'h40, 1'b1, 32'hDEADBEEF, 4'hF, 2'd1, 1'b1);
        #1;
        check("a_sram_req", 64'(sram_req), 64'(1));
        check("a_sram_we", 64'(sram_we), 64'(1));
        check("a_sram_addr", 64'(sram_addr), 64'(10'h10));
        check("a_sram_wdata", 64'(sram_wdata), 64'(32'hDEADBEEF));
        tick();
        set_req(32'h40, 1'b0, 32'h0, 4'h0, 2'd3, 1'b1);
        #1;
        check("a_rd_sram_we", 64'(sram_we), 64'(0));
        check("a_rd_sram_addr", 64'(sram_addr), 64'(10'h10));
        check("a_no_rsp_yet", 64'(rsp_valid), 64'(0));
        tick();
        set_req(32'h40, 1'b1, 32'h11223344, 4'b0101, 2'd2, 1'b1);
        #1;
        check("strb_sram_be", 64'(sram_be), 64'(4'b0101));
        check("strb_sram_wdata", 64'(sram_wdata), 64'(32'h11223344));
        check("a_wr_rsp_valid", 64'(rsp_valid), 64'(1));
        check("a_wr_rsp_write", 64'(rsp.write), 64'(1));
        check("a_wr_rsp_rdata", 64'(rsp.rdata), 64'(0));
        check("a_wr_rsp_sel", 64'(rsp_sel), 64'(1));
        tick();
        set_req(32'h40, 1'b0, 32'h0, 4'h0, 2'd0, 1'b1);
        #1;
        check("a_rd_rsp_valid", 64'(rsp_valid), 64'(1));
        check("a_rd_rsp_rdata", 64'(rsp.rdata), 64'(32'hDEADBEEF));
        check("a_rd_rsp_write", 64'(rsp.write), 64'(0));
        check("a_rd_rsp_sel", 64'(rsp_sel), 64'(3));
        tick();
        req_valid = 1'b0;
        #1;
        check("strb_wr_rsp_sel", 64'(rsp_sel), 64'(2));
        check("strb_wr_rsp_write", 64'(rsp.write), 64'(1));
        tick();
        #1;
        check("strb_rd_rdata", 64'(rsp.rdata), 64'(32'hDE22BE44));
        check("strb_rd_sel", 64'(rsp_sel), 64'(0));
        tick();
        #1;
        check("a_idle_valid", 64'(rsp_valid), 64'(0));
        check("a_idle_rdata", 64'(rsp.rdata), 64'(0));
        check("a_idle_sel", 64'(rsp_sel), 64'(0));
        tick();

        // Backpressure: six reads offered, only four fit.
        reset_book();
        rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) items.push_back(make_rd(32'h100 + k, k % 4));
        repeat (8) step();
        #1;
        check("bp_accepts", 64'(n_acc), 64'(4));
        check("bp_ready_low", 64'(req_ready), 64'(0));
        check("bp_stall_valid", 64'(rsp_valid), 64'(1));
        check("bp_stall_sel", 64'(rsp_sel), 64'(0));
        check("bp_stall_rdata", 64'(rsp.rdata), 64'(32'hA000_0100));
        tick();
        #1;
        check("bp_hold_sel", 64'(rsp_sel), 64'(0));
        check("bp_hold_rdata", 64'(rsp.rdata), 64'(32'hA000_0100));
        tick();
        rsp_ready = 1'b1;
        #1;
        check("bp_ready_on_retire", 64'(req_ready), 64'(0));
        step();
        #1;
        check("bp_ready_next", 64'(req_ready), 64'(1));
        guard = 0;
        while (n_ret < 6 && guard < 40) begin
            step();
            guard++;
        end
        check("bp_drained", 64'(n_ret), 64'(6));
        check("bp_all_accepted", 64'(n_acc), 64'(6));

        // Streaming: 16 back-to-back reads with ready held high.
        reset_book();
        for (int k = 0; k < 16; k++) items.push_back(make_rd(32'h200 + k, (k * 3) % 4));
        guard = 0;
        while (n_ret < 16 && guard < 60) begin
            step();
            guard++;
        end
        check("st_responses", 64'(n_ret), 64'(16));
        check("st_accept_span", 64'(last_acc - first_acc), 64'(15));
        check("st_rsp_span", 64'(last_ret - first_ret), 64'(15));
        check("st_latency", 64'(first_ret - first_acc), 64'(SramLatency));

        // Simultaneous accept and retire at two outstanding.
        reset_book();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) items.push_back(make_rd(32'h300 + k, k + 1));
        offer_limit = 2;
        repeat (4) step();
        offer_limit = 3;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        check("sim_accepts", 64'(n_acc), 64'(3));
        check("sim_retires", 64'(n_ret), 64'(1));
        check("sim_outstanding", 64'(u_dut.outstanding_reg), 64'(2));
        for (int k = 3; k < 7; k++) items.push_back(make_rd(32'h300 + k, k % 4));
        offer_limit = 7;
        repeat (6) step();
        check("sim_room_left", 64'(n_acc), 64'(5));
        rsp_ready = 1'b1;
        guard = 0;
        while (n_ret < 7 && guard < 40) begin
            step();
            guard++;
        end
        check("sim_drained", 64'(n_ret), 64'(7));

        // Reset with three requests in flight.
        reset_book();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) items.push_back(make_rd(32'h380 + k, k));
        repeat (3) step();
        check("rm_accepts", 64'(n_acc), 64'(3));
        rst = 1'b1;
        set_req(32'h44, 1'b0, 32'h0, 4'h0, 2'd2, 1'b1);
        #1;
        check("rm_ready_low", 64'(req_ready), 64'(0));
        check("rm_valid_low", 64'(rsp_valid), 64'(0));
        check("rm_sram_req", 64'(sram_req), 64'(0));
        check("rm_sram_addr", 64'(sram_addr), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rm_ready_first", 64'(req_ready), 64'(1));
        reset_book();
        offer_limit = 0;
        rsp_ready = 1'b1;
        repeat (10) step();
        check("rm_no_rsp", 64'(n_ret), 64'(0));
        check("rm_idle_valid", 64'(rsp_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_responder.md
TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

Interface
REQ-001 SHALL have parameter NumInp, default 4: number of requesters; SrcWidth = max(1, $clog2(NumInp)).
REQ-002 SHALL have parameter DataWidth, default 32: data width in bits; StrbWidth = DataWidth/8.
REQ-003 SHALL have parameter SramAddrWidth, default 10: word address width of the bank SRAM.
REQ-004 SHALL have parameter SramLatency, default 1, legal 1..3: cycles from sram_req_o to valid sram_rdata_i.
REQ-005 SHALL have parameter RspDepth, default 4, legal >= 1: response buffer entries and maximum outstanding requests.
REQ-006 SHALL have parameter types bank_req_t {addr, write, wdata, strb} and bank_rsp_t {rdata, write}.
REQ-007 SHALL have ports: one clock; reset is asynchronous and active-high.
REQ-008 clk_i  in  1  clock, rising edge.
REQ-009 rst_i  in  1  asynchronous active-high reset.
REQ-010 req_i  in  bank_req_t  request payload from the crossbar output.
REQ-011 req_src_i  in  SrcWidth  requester index delivered with the request.
REQ-012 req_valid_i / req_ready_o  in/out  1  request handshake.
REQ-013 rsp_o  out  bank_rsp_t  response payload.
REQ-014 rsp_sel_o  out  SrcWidth  requester index for routing the response back.
REQ-015 rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
REQ-016 sram_req_o, sram_we_o  out  1  SRAM access strobe and write enable.
REQ-017 sram_addr_o  out  SramAddrWidth; sram_wdata_o  out  DataWidth; sram_be_o  out  StrbWidth.
REQ-018 sram_rdata_i  in  DataWidth  SRAM read data.

Function
REQ-019 SHALL accept a request when req_valid_i && req_ready_o, and issue the SRAM access combinationally in that same cycle.
REQ-020 SHALL drive sram_addr_o = req_i.addr[log2(StrbWidth) +: SramAddrWidth], sram_we_o = req_i.write, sram_wdata_o = req_i.wdata, sram_be_o = req_i.strb; all SRAM outputs SHALL be 0 when no request is accepted.
REQ-021 SHALL carry {valid, write, src} through a SramLatency-deep shift pipeline that advances every cycle and never stalls.
REQ-022 SHALL, at pipeline exit, push {rdata = write ? 0 : sram_rdata_i, write, src} into the response FIFO.
REQ-023 SHALL keep an outstanding counter of width $clog2(RspDepth+1) = in-pipeline entries + FIFO entries; +1 on accept, -1 on response handshake, unchanged when both occur in the same cycle.
REQ-024 SHALL drive req_ready_o = (outstanding < RspDepth) && !rst_i; the FIFO therefore never overflows and a push is never dropped.
REQ-025 SHALL present the response fall-through: with an empty FIFO, rsp_valid_o rises exactly SramLatency cycles after acceptance.
REQ-026 SHALL return responses strictly in acceptance order, with rsp_sel_o equal to the req_src_i captured at acceptance.
REQ-027 SHALL hold rsp_o and rsp_sel_o stable while rsp_valid_o && !rsp_ready_i; rsp_o and rsp_sel_o SHALL be 0 while rsp_valid_o is low.
REQ-028 SHALL sustain one request and one response per cycle when rsp_ready_i is held high.
REQ-029 SHALL, when FIFO is full and outstanding == RspDepth, accept a new request in the same cycle a response handshake completes only on the following cycle (ready is derived from the registered counter).

Reset
REQ-030 SHALL, while rst_i is high, clear the pipeline, FIFO and counter, and force req_ready_o=0, rsp_valid_o=0, sram_req_o=0, and all other outputs to 0.
REQ-031 SHALL discard in-flight requests and buffered responses on reset asserted mid-operation; none SHALL appear after reset release.
REQ-032 SHALL assert req_ready_o in the first cycle after rst_i deasserts.

Structure
REQ-033 SHALL place the bank_req_t/bank_rsp_t field layouts and the legal SramLatency/RspDepth bounds in the shared snitch_pkg.
REQ-034 SHALL use a single sub-module, fifo_v3 (common_cells, FallThrough=1, depth RspDepth), as the response buffer.

Verification
REQ-035 Single read, SramLatency=2: write 0xDEADBEEF to addr 0x40 from src 1, then read 0x40 from src 3 -> read rsp rdata=0xDEADBEEF, rsp_sel_o=3, valid 2 cycles after accept; write rsp rdata=0, write=1, rsp_sel_o=1.
REQ-036 Backpressure: rsp_ready_i=0, RspDepth=4, 6 requests offered -> exactly 4 accepted, req_ready_o low thereafter; release -> 4 in-order responses, then the 2 remaining accepted.
REQ-037 Streaming: 16 back-to-back reads with rsp_ready_i=1 -> 16 accepts in 16 cycles, responses in order, no bubbles.
REQ-038 Simultaneous accept and retire at outstanding=2 -> counter stays 2.
REQ-039 Reset mid-operation with 3 outstanding -> no responses after release, req_ready_o=1 on first post-reset cycle.
REQ-040 Byte strobe: write 0x11223344 with strb=0b0101 -> sram_be_o=0b0101 in the accept cycle.
